// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode map, compare modes, sel_b codes and stage bundle types for control_pipe
package ctrl_pkg;
  localparam int OPC_W = 4;
  localparam int CMP_W = 2;
  localparam int RA_W = 4;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_AND = 4'b0011,
                               OP_OR = 4'b0100, OP_XOR = 4'b0101, OP_NOT = 4'b0110, OP_SHL = 4'b0111,
                               OP_CMP = 4'b1000, OP_SHR = 4'b1001, OP_SRA = 4'b1010, OP_LI = 4'b1011,
                               OP_LOAD = 4'b1100, OP_STORE = 4'b1101, OP_BR = 4'b1110, OP_NOP = 4'b1111;
  typedef enum logic [CMP_W-1:0] {CMP_NOP, CMP_LT, CMP_EQ, CMP_LE} cmp_mode_t;
  localparam logic [1:0] SEL_ALU = 2'd0, SEL_LOAD = 2'd1, SEL_STORE = 2'd2;
  typedef struct packed {
    logic [OPC_W+CMP_W-1:0] alu_control;
    logic [1:0] sel_b;
    logic alu_mux;
    logic cmp_en;
    logic branch;
    logic mem_we;
    logic mem_re;
    logic reg_we;
    logic sel_data_out;
  } ctrl_bundle_t;
  typedef struct packed {
    logic valid;
    ctrl_bundle_t c;
    logic [RA_W-1:0] rd;
  } ex_t;
  typedef struct packed {
    logic valid;
    logic mem_we;
    logic mem_re;
    logic reg_we;
    logic sel_data_out;
    logic [RA_W-1:0] rd;
  } mem_t;
  typedef struct packed {
    logic valid;
    logic reg_we;
    logic sel_data_out;
    logic [RA_W-1:0] rd;
  } wb_t;
  function automatic logic is_sys(input logic [OPC_W-1:0] op);
    return op[3:1] == 3'b111;
  endfunction
endpackage

// File: rtl/control_pipe_if.sv
// control_pipe_if: ID inputs and stage control outputs of control_pipe; PERF_CNT_EN adds stall_cnt/flush_cnt
interface control_pipe_if;
  import ctrl_pkg::*;
  logic id_valid;
  logic [OPC_W-1:0] id_opcode;
  logic [CMP_W-1:0] id_cmp_flag;
  logic [RA_W-1:0] id_rs_a, id_rs_b, id_rd;
  logic ex_branch_taken;
  logic stall, flush, id_re_a, id_re_b;
  logic ex_valid;
  logic [OPC_W+CMP_W-1:0] ex_alu_control;
  logic [1:0] ex_sel_b;
  logic ex_alu_mux, ex_cmp_en, ex_branch;
  logic mem_valid, mem_we, mem_re;
  logic wb_valid, wb_reg_we, wb_sel_data_out;
  logic [RA_W-1:0] wb_rd;
`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  modport master(
    output id_valid, id_opcode, id_cmp_flag, id_rs_a, id_rs_b, id_rd, ex_branch_taken,
    input stall, flush, id_re_a, id_re_b, ex_valid, ex_alu_control, ex_sel_b, ex_alu_mux, ex_cmp_en,
    ex_branch, mem_valid, mem_we, mem_re, wb_valid, wb_reg_we, wb_sel_data_out, wb_rd
`ifdef PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );
  modport slave(
    input id_valid, id_opcode, id_cmp_flag, id_rs_a, id_rs_b, id_rd, ex_branch_taken,
    output stall, flush, id_re_a, id_re_b, ex_valid, ex_alu_control, ex_sel_b, ex_alu_mux, ex_cmp_en,
    ex_branch, mem_valid, mem_we, mem_re, wb_valid, wb_reg_we, wb_sel_data_out, wb_rd
`ifdef PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode to control bundle decode, all outputs gated by valid
module ctrl_decode import ctrl_pkg::*; (
  input  logic valid,
  input  logic [OPC_W-1:0] opcode,
  input  logic [CMP_W-1:0] cmp_flag,
  output ctrl_bundle_t bundle,
  output logic re_a,
  output logic re_b
);
  ctrl_bundle_t d;
  always_comb begin
    d = '0;
    d.alu_control = {opcode, cmp_flag};
    d.mem_we = opcode == OP_STORE;
    d.mem_re = opcode == OP_LOAD;
    d.sel_b = d.mem_we ? SEL_STORE : d.mem_re ? SEL_LOAD : SEL_ALU;
    d.alu_mux = opcode == OP_LI;
    d.cmp_en = opcode == OP_CMP;
    d.branch = opcode == OP_BR;
    d.reg_we = !(opcode == OP_CMP || opcode == OP_STORE || is_sys(opcode));
    d.sel_data_out = d.mem_re;
  end
  assign bundle = valid ? d : '0;
  assign re_a = valid && !(opcode == OP_LI || is_sys(opcode));
  assign re_b = valid && !(opcode == OP_NOT || opcode == OP_LI || opcode == OP_LOAD || is_sys(opcode));
endmodule

// File: rtl/control_pipe.sv
// control_pipe: pipelined control decode with MUL hold, load-use stall and branch flush; PERF_CNT_EN adds counters
module control_pipe import ctrl_pkg::*; #(
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst,
  control_pipe_if.slave p
);
  ctrl_bundle_t id_c;
  logic re_a, re_b, hold, load_use, flush_now, stall_now, take;
  logic [3:0] busy_cnt;
  ex_t ex_q, id_s;
  mem_t mem_q;
  wb_t wb_q;
  ctrl_decode u_dec (
    .valid(p.id_valid), .opcode(p.id_opcode), .cmp_flag(p.id_cmp_flag),
    .bundle(id_c), .re_a(re_a), .re_b(re_b)
  );
  assign id_s = ex_t'{valid: p.id_valid, c: id_c, rd: p.id_rd};
  assign hold = busy_cnt != '0;
  assign load_use = ex_q.valid && ex_q.c.mem_re &&
                    ((ex_q.rd == p.id_rs_a && re_a) || (ex_q.rd == p.id_rs_b && re_b));
  assign flush_now = ex_q.valid && ex_q.c.branch && p.ex_branch_taken;
  assign stall_now = !flush_now && (hold || load_use);
  assign take = !flush_now && !hold && !load_use;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      busy_cnt <= '0;
    end else begin
      ex_q <= take ? id_s : (hold && !flush_now) ? ex_q : '0;
      mem_q <= hold ? '0 : mem_t'{valid: ex_q.valid, mem_we: ex_q.c.mem_we, mem_re: ex_q.c.mem_re,
                                  reg_we: ex_q.c.reg_we, sel_data_out: ex_q.c.sel_data_out, rd: ex_q.rd};
      wb_q <= wb_t'{valid: mem_q.valid, reg_we: mem_q.reg_we, sel_data_out: mem_q.sel_data_out, rd: mem_q.rd};
      busy_cnt <= (take && p.id_valid && p.id_opcode == OP_MUL) ? 4'(MUL_LAT - 1) : hold ? busy_cnt - 4'd1 : '0;
    end
  assign p.stall = stall_now;
  assign p.flush = flush_now;
  assign p.id_re_a = re_a;
  assign p.id_re_b = re_b;
  assign p.ex_valid = ex_q.valid;
  assign p.ex_alu_control = ex_q.c.alu_control;
  assign p.ex_sel_b = ex_q.c.sel_b;
  assign p.ex_alu_mux = ex_q.c.alu_mux;
  assign p.ex_cmp_en = ex_q.c.cmp_en;
  assign p.ex_branch = ex_q.c.branch;
  assign p.mem_valid = mem_q.valid;
  assign p.mem_we = mem_q.mem_we;
  assign p.mem_re = mem_q.mem_re;
  assign p.wb_valid = wb_q.valid;
  assign p.wb_reg_we = wb_q.reg_we;
  assign p.wb_sel_data_out = wb_q.sel_data_out;
  assign p.wb_rd = wb_q.rd;
`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 16'(stall_now && stall_cnt != 16'hFFFF);
      flush_cnt <= flush_cnt + 16'(flush_now && flush_cnt != 16'hFFFF);
    end
  assign p.stall_cnt = stall_cnt;
  assign p.flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed self-checking bench for control_pipe (MUL_LAT = 3)
module tb_control_pipe;
  import ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  control_pipe_if p();
  control_pipe #(.MUL_LAT(3)) dut (.clk(clk), .rst(rst), .p(p));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input logic [1:0] cf, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rd);
    p.id_valid = 1'b1;
    p.id_opcode = op;
    p.id_cmp_flag = cf;
    p.id_rs_a = ra;
    p.id_rs_b = rb;
    p.id_rd = rd;
  endtask
  task automatic idle;
    p.id_valid = 1'b0;
  endtask
  task automatic send(input logic [3:0] op, input logic [1:0] cf, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] rd);
    int n = 0;
    drive(op, cf, ra, rb, rd);
    #1;
    while (p.stall && n < 20) begin
      cyc;
      #1;
      n++;
    end
    if (n == 20) check("send_timeout", 32'd1, 32'd0);
    cyc;
  endtask
  initial begin
    rst = 1'b1;
    p.ex_branch_taken = 1'b0;
    drive(OP_NOP, 2'd0, 4'd0, 4'd0, 4'd0);
    idle;
    repeat (2) cyc;
    check("rst_ex_valid", p.ex_valid, 0);
    check("rst_stall", p.stall, 0);
    check("rst_flush", p.flush, 0);
    rst = 1'b0;
    drive(OP_ADD, 2'd0, 4'd1, 4'd2, 4'd1);
    #1 check("add_re_a", p.id_re_a, 1);
    cyc;
    check("add_ex_valid", p.ex_valid, 1);
    check("add_alu", p.ex_alu_control, 6'h00);
    drive(OP_STORE, 2'd0, 4'd2, 4'd1, 4'd0);
    cyc;
    check("st_sel_b", p.ex_sel_b, 2'b10);
    check("st_alu", p.ex_alu_control, 6'h34);
    idle;
    #1 check("idle_re_a", p.id_re_a, 0);
    cyc;
    check("add_wb_we", p.wb_reg_we, 1);
    check("add_wb_rd", p.wb_rd, 1);
    check("st_mem_we", p.mem_we, 1);
    cyc;
    check("st_wb_valid", p.wb_valid, 1);
    check("st_wb_we", p.wb_reg_we, 0);
    drive(OP_LI, 2'd0, 4'd3, 4'd3, 4'd2);
    #1 check("li_re_a", p.id_re_a, 0);
    check("li_re_b", p.id_re_b, 0);
    drive(OP_LOAD, 2'd0, 4'd5, 4'd0, 4'd3);
    cyc;
    check("ld_sel_b", p.ex_sel_b, 2'b01);
    drive(OP_ADD, 2'd0, 4'd4, 4'd3, 4'd6);
    #1 check("lu_stall", p.stall, 1);
    check("lu_flush", p.flush, 0);
    cyc;
    check("lu_bubble", p.ex_valid, 0);
    check("ld_mem_re", p.mem_re, 1);
    check("lu_stall_once", p.stall, 0);
    cyc;
    check("lu_add_ex", p.ex_valid, 1);
    check("lu_add_alu", p.ex_alu_control, 6'h00);
    check("ld_wb_sel", p.wb_sel_data_out, 1);
    check("ld_wb_rd", p.wb_rd, 3);
    drive(OP_LOAD, 2'd0, 4'd1, 4'd0, 4'd3);
    cyc;
    drive(OP_ADD, 2'd0, 4'd7, 4'd8, 4'd6);
    #1 check("nolu_stall", p.stall, 0);
    cyc;
    check("nolu_ex_sel_b", p.ex_sel_b, 2'b00);
    drive(OP_MUL, 2'd0, 4'd1, 4'd2, 4'd4);
    cyc;
    check("mul_alu", p.ex_alu_control, 6'h08);
    check("mul_mem_prev", p.mem_valid, 1);
    drive(OP_ADD, 2'd1, 4'd9, 4'd10, 4'd11);
    #1 check("mul_stall1", p.stall, 1);
    cyc;
    check("mul_bubble1", p.mem_valid, 0);
    check("mul_stall2", p.stall, 1);
    check("mul_hold1", p.ex_alu_control, 6'h08);
    cyc;
    check("mul_bubble2", p.mem_valid, 0);
    check("mul_stall3", p.stall, 0);
    check("mul_hold2", p.ex_alu_control, 6'h08);
    cyc;
    check("mul_next_ex", p.ex_alu_control, 6'h01);
    check("mul_leaves", p.mem_valid, 1);
    drive(OP_BR, 2'd1, 4'd0, 4'd0, 4'd5);
    cyc;
    check("br_ex", p.ex_branch, 1);
    p.ex_branch_taken = 1'b1;
    drive(OP_ADD, 2'd0, 4'd5, 4'd5, 4'd1);
    #1 check("br_flush", p.flush, 1);
    check("br_no_stall", p.stall, 0);
    cyc;
    check("br_bubble", p.ex_valid, 0);
    p.ex_branch_taken = 1'b0;
    drive(OP_BR, 2'd1, 4'd0, 4'd0, 4'd5);
    cyc;
    check("brn_ex", p.ex_branch, 1);
    drive(OP_CMP, 2'd2, 4'd1, 4'd2, 4'd0);
    #1 check("brn_flush", p.flush, 0);
    cyc;
    check("cmp_ex_valid", p.ex_valid, 1);
    check("cmp_en", p.ex_cmp_en, 1);
    check("cmp_alu", p.ex_alu_control, 6'h22);
    drive(OP_MUL, 2'd0, 4'd1, 4'd1, 4'd1);
    cyc;
    check("mul2_stall", p.stall, 1);
    rst = 1'b1;
    #1 check("mid_rst_stall", p.stall, 0);
    check("mid_rst_ex", p.ex_valid, 0);
    check("mid_rst_mem", p.mem_valid, 0);
    check("mid_rst_wb", p.wb_valid, 0);
    check("mid_rst_alu", p.ex_alu_control, 0);
    check("mid_rst_flush", p.flush, 0);
    idle;
    repeat (2) cyc;
    rst = 1'b0;
    cyc;
    check("post_rst_stall", p.stall, 0);
`ifdef PERF_CNT_EN
    check("cnt_clr", p.stall_cnt, 0);
    send(OP_LOAD, 2'd0, 4'd1, 4'd0, 4'd3);
    send(OP_ADD, 2'd0, 4'd3, 4'd0, 4'd4);
    send(OP_LOAD, 2'd0, 4'd1, 4'd0, 4'd5);
    send(OP_ADD, 2'd0, 4'd0, 4'd5, 4'd6);
    send(OP_MUL, 2'd0, 4'd1, 4'd2, 4'd7);
    send(OP_ADD, 2'd0, 4'd8, 4'd9, 4'd10);
    send(OP_BR, 2'd1, 4'd0, 4'd0, 4'd0);
    p.ex_branch_taken = 1'b1;
    send(OP_ADD, 2'd0, 4'd1, 4'd2, 4'd3);
    p.ex_branch_taken = 1'b0;
    idle;
    cyc;
    check("stall_cnt", p.stall_cnt, 16'd4);
    check("flush_cnt", p.flush_cnt, 16'd1);
    force dut.stall_now = 1'b1;
    repeat (70000) cyc;
    release dut.stall_now;
    cyc;
    check("stall_cnt_sat", p.stall_cnt, 16'hFFFF);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
